// File: rtl/mac_pe.sv
// Systolic multiply-accumulate processing element: forwards operands east/south
// and accumulates a*b into a dot product that is handed off through a valid/ready port.
//
// state | meaning
// IDLE  | no tile in progress, accumulator is zero
// ACCUM | tile in progress, accumulator holds a partial sum
module mac_pe #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              stall,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              out_valid,
    output logic              out_last,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow,
    output logic              drop_err
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;
    logic             ext_acc;
    logic             ext_prod;
    logic [ACC_W:0]   sum_x;
    logic             ovf;
    logic [ACC_W-1:0] sat_val;
    logic [ACC_W-1:0] result;
    logic             step;
    logic             load;

    // Operands are widened to ACC_W first; the low ACC_W bits of the product are
    // exact because ACC_W >= 2*DATA_W, and identical for signed and unsigned.
    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext    = ACC_W'($signed(a_out));
            assign b_ext    = ACC_W'($signed(b_out));
            assign ext_acc  = acc_base[ACC_W-1];
            assign ext_prod = prod[ACC_W-1];
            assign ovf      = sum_x[ACC_W] ^ sum_x[ACC_W-1];
            assign sat_val  = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin : g_unsigned
            assign a_ext    = ACC_W'(a_out);
            assign b_ext    = ACC_W'(b_out);
            assign ext_acc  = 1'b0;
            assign ext_prod = 1'b0;
            assign ovf      = sum_x[ACC_W];
            assign sat_val  = {ACC_W{1'b1}};
        end
    endgenerate

    assign acc_base = (state == IDLE) ? '0 : acc;
    assign prod     = a_ext * b_ext;
    assign sum_x    = {ext_acc, acc_base} + {ext_prod, prod};
    assign result   = (ovf && (SATURATE != 0)) ? sat_val : sum_x[ACC_W-1:0];
    assign step     = out_valid && !stall;
    assign load     = step && out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            b_out     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            a_out     <= a_in;
            b_out     <= b_in;
            out_valid <= in_valid;
            out_last  <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            overflow  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (step) begin
                if (ovf) overflow <= 1'b1;
                if (out_last) begin
                    acc     <= '0;
                    acc_out <= result;
                    state   <= IDLE;
                end else begin
                    acc     <= result;
                    state   <= ACCUM;
                end
            end
            // The result handshake runs even while the datapath is stalled.
            if (load) begin
                acc_valid <= 1'b1;
                if (acc_valid && !acc_ready) drop_err <= 1'b1;
            end else if (acc_valid && acc_ready) begin
                acc_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Directed test of mac_pe: default 40-bit signed saturating instance plus
// 32-bit saturating and wrapping instances for the overflow vectors.
module tb_mac_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_in, b_in;
    logic        in_valid, in_last, stall, acc_ready;

    logic [15:0] d_a_out, d_b_out, s_a_out, s_b_out, w_a_out, w_b_out;
    logic        d_out_valid, d_out_last, s_out_valid, s_out_last, w_out_valid, w_out_last;
    logic [39:0] d_acc_out;
    logic [31:0] s_acc_out, w_acc_out;
    logic        d_acc_valid, s_acc_valid, w_acc_valid;
    logic        d_overflow, s_overflow, w_overflow;
    logic        d_drop_err, s_drop_err, w_drop_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_pe #(.DATA_W(16), .ACC_W(40), .SIGNED(1), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_last(in_last), .stall(stall), .a_out(d_a_out), .b_out(d_b_out),
        .out_valid(d_out_valid), .out_last(d_out_last), .acc_out(d_acc_out),
        .acc_valid(d_acc_valid), .acc_ready(acc_ready), .overflow(d_overflow),
        .drop_err(d_drop_err)
    );

    mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1), .SATURATE(1)) u_sat32 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_last(in_last), .stall(stall), .a_out(s_a_out), .b_out(s_b_out),
        .out_valid(s_out_valid), .out_last(s_out_last), .acc_out(s_acc_out),
        .acc_valid(s_acc_valid), .acc_ready(acc_ready), .overflow(s_overflow),
        .drop_err(s_drop_err)
    );

    mac_pe #(.DATA_W(16), .ACC_W(32), .SIGNED(1), .SATURATE(0)) u_wrap32 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_last(in_last), .stall(stall), .a_out(w_a_out), .b_out(w_b_out),
        .out_valid(w_out_valid), .out_last(w_out_last), .acc_out(w_acc_out),
        .acc_valid(w_acc_valid), .acc_ready(acc_ready), .overflow(w_overflow),
        .drop_err(w_drop_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs settle 1 time unit after an edge; outputs are read at that point too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic v, input logic l);
        a_in     = a;
        b_in     = b;
        in_valid = v;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        drive(16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a_in = '0; b_in = '0; in_valid = 1'b0; in_last = 1'b0;
        stall = 1'b0; acc_ready = 1'b1;
        do_reset();
        chk("rst_acc_out",   d_acc_out,   0);
        chk("rst_acc_valid", d_acc_valid, 0);
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_flags",     {d_overflow, d_drop_err}, 0);

        // (3,4) then (5,6,last) -> 42
        drive(16'd3, 16'd4, 1'b1, 1'b0);
        chk("fwd_a",        d_a_out, 3);
        chk("fwd_b",        d_b_out, 4);
        chk("fwd_valid",    d_out_valid, 1);
        drive(16'd5, 16'd6, 1'b1, 1'b1);
        chk("dot_early",    d_acc_valid, 0);
        idle();
        chk("dot_valid",    d_acc_valid, 1);
        chk("dot_value",    d_acc_out, 42);
        idle();
        chk("dot_one_cyc",  d_acc_valid, 0);

        // (-2,7,last) -> -14 sign-extended
        drive(16'hFFFE, 16'd7, 1'b1, 1'b1);
        chk("neg_fwd_a",    d_a_out, 16'hFFFE);
        chk("neg_fwd_last", {d_out_valid, d_out_last}, 2'b11);
        idle();
        chk("neg_value",    d_acc_out, 40'hFF_FFFF_FFF2);
        chk("neg_valid",    d_acc_valid, 1);
        chk("neg_fwd_idle", d_out_valid, 0);
        idle();

        // 3 x 0x7FFF^2 : overflows 32 bits, fits in 40
        drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        idle();
        chk("sat32_value",  s_acc_out, 32'h7FFF_FFFF);
        chk("sat32_ovf",    s_overflow, 1);
        chk("wrap32_value", w_acc_out, 32'hBFFD_0003);
        chk("wrap32_ovf",   w_overflow, 1);
        chk("w40_value",    d_acc_out, 40'h00_BFFD_0003);
        chk("w40_no_ovf",   d_overflow, 0);
        idle();
        do_reset();

        // consumer not ready across two tiles -> overwrite and drop_err
        acc_ready = 1'b0;
        drive(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        chk("hold_first",   d_acc_out, 1);
        chk("hold_no_drop", d_drop_err, 0);
        drive(16'd2, 16'd2, 1'b1, 1'b1);
        idle();
        chk("drop_value",   d_acc_out, 4);
        chk("drop_flag",    d_drop_err, 1);
        idle();
        chk("drop_held",    d_acc_valid, 1);
        acc_ready = 1'b1;
        tick();
        chk("drop_consumed", d_acc_valid, 0);
        chk("drop_sticky",   d_drop_err, 1);

        // (2,2), 3-cycle stall with junk on the inputs, then (3,3,last) -> 13
        drive(16'd2, 16'd2, 1'b1, 1'b0);
        stall = 1'b1;
        drive(16'd7, 16'd7, 1'b1, 1'b1);
        drive(16'd7, 16'd7, 1'b1, 1'b1);
        drive(16'd7, 16'd7, 1'b1, 1'b1);
        chk("stall_a_hold",    d_a_out, 2);
        chk("stall_last_hold", d_out_last, 0);
        chk("stall_no_result", d_acc_valid, 0);
        stall = 1'b0;
        drive(16'd3, 16'd3, 1'b1, 1'b1);
        idle();
        chk("stall_value",  d_acc_out, 13);
        chk("stall_valid",  d_acc_valid, 1);
        idle();

        // reset mid-tile (with stall asserted) discards the partial sum
        drive(16'd9, 16'd9, 1'b1, 1'b0);
        idle();
        stall = 1'b1;
        do_reset();
        stall = 1'b0;
        chk("rst2_out",     {d_acc_valid, d_out_valid, d_acc_out}, 0);
        drive(16'd1, 16'd1, 1'b1, 1'b1);
        idle();
        chk("fresh_value",  d_acc_out, 1);
        chk("fresh_ovf",    d_overflow, 0);
        chk("fresh_drop",   d_drop_err, 0);
        chk("fresh_valid",  d_acc_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
